// File: rtl/dm_cache_ctrl.sv
// Direct-mapped, write-through, no-write-allocate cache controller with registered lookup,
// multi-beat line refill, line-by-line flush and saturating hit/miss counters.
module dm_cache_ctrl #(
  parameter int unsigned ADDR_W   = 16,
  parameter int unsigned DATA_W   = 32,
  parameter int unsigned INDEX_W  = 8,
  parameter int unsigned OFFSET_W = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              resp_valid,
  output logic [DATA_W-1:0] resp_rdata,
  input  logic              flush,
  output logic              flush_busy,
  output logic              mem_req_valid,
  input  logic              mem_req_ready,
  output logic              mem_req_we,
  output logic [ADDR_W-1:0] mem_req_addr,
  output logic [DATA_W-1:0] mem_req_wdata,
  input  logic              mem_resp_valid,
  input  logic [DATA_W-1:0] mem_resp_rdata,
  output logic [31:0]       stat_hits,
  output logic [31:0]       stat_misses
);

  localparam int unsigned TAG_W = ADDR_W - INDEX_W - OFFSET_W;
  localparam int unsigned LINES = 2 ** INDEX_W;
  localparam int unsigned WORDS = 2 ** OFFSET_W;

  typedef enum logic [2:0] {
    StIdle,
    StLookup,
    StRefillReq,
    StRefillWait,
    StWrite,
    StRespond,
    StFlush
  } state_e;

  state_e              state_q, state_d;
  logic                we_q, we_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [DATA_W-1:0]   wdata_q, wdata_d;
  logic [OFFSET_W-1:0] beat_q, beat_d;
  logic [INDEX_W-1:0]  flush_idx_q, flush_idx_d;
  logic                flush_pend_q, flush_pend_d;
  logic [31:0]         hits_q, hits_d, misses_q, misses_d;
  logic [DATA_W-1:0]   rdata_q, rdata_d;
  logic                mem_valid_q, mem_valid_d;
  logic                mem_we_q, mem_we_d;
  logic [ADDR_W-1:0]   mem_addr_q, mem_addr_d;
  logic [DATA_W-1:0]   mem_wdata_q, mem_wdata_d;
  logic [LINES-1:0]    valid_q, valid_d;

  logic [TAG_W-1:0]    tag_mem  [LINES];
  logic [DATA_W-1:0]   data_mem [LINES*WORDS];

  logic [TAG_W-1:0]            cur_tag;
  logic [INDEX_W-1:0]          cur_idx;
  logic [OFFSET_W-1:0]         cur_off;
  logic [OFFSET_W-1:0]         beat_nxt;
  logic                        hit;
  logic [DATA_W-1:0]           data_rd;
  logic                        data_we;
  logic [INDEX_W+OFFSET_W-1:0] data_waddr;
  logic [DATA_W-1:0]           data_wdata;
  logic                        tag_we;

  assign cur_tag  = addr_q[ADDR_W-1 -: TAG_W];
  assign cur_idx  = addr_q[OFFSET_W +: INDEX_W];
  assign cur_off  = addr_q[OFFSET_W-1:0];
  assign beat_nxt = beat_q + 1'b1;
  assign hit      = valid_q[cur_idx] && (tag_mem[cur_idx] == cur_tag);
  assign data_rd  = data_mem[{cur_idx, cur_off}];

  always_comb begin
    state_d      = state_q;
    we_d         = we_q;
    addr_d       = addr_q;
    wdata_d      = wdata_q;
    beat_d       = beat_q;
    flush_idx_d  = flush_idx_q;
    flush_pend_d = flush_pend_q | flush;
    hits_d       = hits_q;
    misses_d     = misses_q;
    rdata_d      = rdata_q;
    mem_valid_d  = mem_valid_q;
    mem_we_d     = mem_we_q;
    mem_addr_d   = mem_addr_q;
    mem_wdata_d  = mem_wdata_q;
    valid_d      = valid_q;
    data_we      = 1'b0;
    data_waddr   = {cur_idx, cur_off};
    data_wdata   = wdata_q;
    tag_we       = 1'b0;

    unique case (state_q)
      StIdle: begin
        // A pending flush wins over a request presented in the same cycle.
        if (flush_pend_q) begin
          flush_idx_d = '0;
          state_d     = StFlush;
        end else if (req_valid) begin
          we_d    = req_we;
          addr_d  = req_addr;
          wdata_d = req_wdata;
          state_d = StLookup;
        end
      end
      StLookup: begin
        if (hit) begin
          if (hits_q != 32'hFFFF_FFFF) hits_d = hits_q + 32'd1;
        end else begin
          if (misses_q != 32'hFFFF_FFFF) misses_d = misses_q + 32'd1;
        end
        if (!we_q) begin
          if (hit) begin
            rdata_d = data_rd;
            state_d = StRespond;
          end else begin
            beat_d      = '0;
            mem_valid_d = 1'b1;
            mem_we_d    = 1'b0;
            mem_addr_d  = {addr_q[ADDR_W-1:OFFSET_W], {OFFSET_W{1'b0}}};
            state_d     = StRefillReq;
          end
        end else begin
          // Write-through: a store hit updates the line, a store miss leaves it untouched.
          data_we     = hit;
          rdata_d     = '0;
          mem_valid_d = 1'b1;
          mem_we_d    = 1'b1;
          mem_addr_d  = addr_q;
          mem_wdata_d = wdata_q;
          state_d     = StWrite;
        end
      end
      StRefillReq: begin
        if (mem_req_ready) begin
          mem_valid_d = 1'b0;
          state_d     = StRefillWait;
        end
      end
      StRefillWait: begin
        if (mem_resp_valid) begin
          data_we    = 1'b1;
          data_waddr = {cur_idx, beat_q};
          data_wdata = mem_resp_rdata;
          if (beat_q == cur_off) rdata_d = mem_resp_rdata;
          if (beat_q == {OFFSET_W{1'b1}}) begin
            tag_we           = 1'b1;
            valid_d[cur_idx] = 1'b1;
            state_d          = StRespond;
          end else begin
            beat_d      = beat_nxt;
            mem_valid_d = 1'b1;
            mem_addr_d  = {addr_q[ADDR_W-1:OFFSET_W], beat_nxt};
            state_d     = StRefillReq;
          end
        end
      end
      StWrite: begin
        if (mem_req_ready) begin
          mem_valid_d = 1'b0;
          mem_we_d    = 1'b0;
          state_d     = StRespond;
        end
      end
      StRespond: begin
        state_d = StIdle;
      end
      StFlush: begin
        valid_d[flush_idx_q] = 1'b0;
        if (flush_idx_q == {INDEX_W{1'b1}}) begin
          // Pulses seen while flushing merge into this flush.
          flush_pend_d = 1'b0;
          state_d      = StIdle;
        end else begin
          flush_idx_d = flush_idx_q + 1'b1;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= StIdle;
      we_q         <= 1'b0;
      addr_q       <= '0;
      wdata_q      <= '0;
      beat_q       <= '0;
      flush_idx_q  <= '0;
      flush_pend_q <= 1'b0;
      hits_q       <= '0;
      misses_q     <= '0;
      rdata_q      <= '0;
      mem_valid_q  <= 1'b0;
      mem_we_q     <= 1'b0;
      mem_addr_q   <= '0;
      mem_wdata_q  <= '0;
      valid_q      <= '0;
    end else begin
      state_q      <= state_d;
      we_q         <= we_d;
      addr_q       <= addr_d;
      wdata_q      <= wdata_d;
      beat_q       <= beat_d;
      flush_idx_q  <= flush_idx_d;
      flush_pend_q <= flush_pend_d;
      hits_q       <= hits_d;
      misses_q     <= misses_d;
      rdata_q      <= rdata_d;
      mem_valid_q  <= mem_valid_d;
      mem_we_q     <= mem_we_d;
      mem_addr_q   <= mem_addr_d;
      mem_wdata_q  <= mem_wdata_d;
      valid_q      <= valid_d;
    end
  end

  always_ff @(posedge clk) begin
    if (data_we) data_mem[data_waddr] <= data_wdata;
    if (tag_we) tag_mem[cur_idx] <= cur_tag;
  end

  assign req_ready     = (state_q == StIdle) && !flush_pend_q && !reset;
  assign resp_valid    = (state_q == StRespond);
  assign resp_rdata    = (state_q == StRespond && !we_q) ? rdata_q : '0;
  assign flush_busy    = flush_pend_q;
  assign mem_req_valid = mem_valid_q;
  assign mem_req_we    = mem_we_q;
  assign mem_req_addr  = mem_addr_q;
  assign mem_req_wdata = mem_wdata_q;
  assign stat_hits     = hits_q;
  assign stat_misses   = misses_q;

endmodule

// File: tb/tb_dm_cache_ctrl.sv
// Directed bench for dm_cache_ctrl: word memory model at negedge, scenarios sampled 1 ns after
// the rising edge.
module tb_dm_cache_ctrl;

  logic        clk;
  logic        reset;
  logic        req_valid, req_ready, req_we;
  logic [15:0] req_addr;
  logic [31:0] req_wdata;
  logic        resp_valid;
  logic [31:0] resp_rdata;
  logic        flush, flush_busy;
  logic        mem_req_valid, mem_req_ready, mem_req_we;
  logic [15:0] mem_req_addr;
  logic [31:0] mem_req_wdata;
  logic        mem_resp_valid;
  logic [31:0] mem_resp_rdata;
  logic [31:0] stat_hits, stat_misses;

  int checks = 0;
  int fails  = 0;

  // Memory model state and traffic log
  logic [31:0] mem [65536];
  logic        pend_rd;
  logic [31:0] pend_data;
  int          n_rd, n_wr, n_stall, n_unstable, stall_cnt;
  logic [15:0] rd_log [8];
  logic [15:0] last_wr_addr, stall_addr;
  logic [31:0] last_wr_data;

  dm_cache_ctrl dut (
    .clk            (clk),
    .reset          (reset),
    .req_valid      (req_valid),
    .req_ready      (req_ready),
    .req_we         (req_we),
    .req_addr       (req_addr),
    .req_wdata      (req_wdata),
    .resp_valid     (resp_valid),
    .resp_rdata     (resp_rdata),
    .flush          (flush),
    .flush_busy     (flush_busy),
    .mem_req_valid  (mem_req_valid),
    .mem_req_ready  (mem_req_ready),
    .mem_req_we     (mem_req_we),
    .mem_req_addr   (mem_req_addr),
    .mem_req_wdata  (mem_req_wdata),
    .mem_resp_valid (mem_resp_valid),
    .mem_resp_rdata (mem_resp_rdata),
    .stat_hits      (stat_hits),
    .stat_misses    (stat_misses)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    mem_req_ready  = 1'b1;
    mem_resp_valid = 1'b0;
    mem_resp_rdata = '0;
    pend_rd        = 1'b0;
    pend_data      = '0;
    for (int i = 0; i < 65536; i++) mem[i] = 32'(i) ^ 32'hA5A5_0000;
    forever begin
      @(negedge clk);
      mem_resp_valid = pend_rd;
      mem_resp_rdata = pend_rd ? pend_data : 32'h0;
      pend_rd        = 1'b0;
      if (stall_cnt > 0 && mem_req_valid) begin
        mem_req_ready = 1'b0;
        stall_cnt--;
        if (n_stall > 0 && (mem_req_addr != stall_addr || mem_req_we)) n_unstable++;
        stall_addr = mem_req_addr;
        n_stall++;
      end else begin
        mem_req_ready = 1'b1;
      end
      if (mem_req_valid && mem_req_ready) begin
        if (mem_req_we) begin
          mem[mem_req_addr] = mem_req_wdata;
          last_wr_addr      = mem_req_addr;
          last_wr_data      = mem_req_wdata;
          n_wr++;
        end else begin
          pend_rd   = 1'b1;
          pend_data = mem[mem_req_addr];
          if (n_rd < 8) rd_log[n_rd] = mem_req_addr;
          n_rd++;
        end
      end
    end
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic clear_log;
    n_rd       = 0;
    n_wr       = 0;
    n_stall    = 0;
    n_unstable = 0;
  endtask

  // Issue one request; lat counts cycles from the accept cycle to the resp_valid cycle.
  task automatic do_req(input logic we, input logic [15:0] a, input logic [31:0] d,
                        output logic [31:0] rd, output int lat);
    int w = 0;
    while (!req_ready && w < 500) begin
      tick;
      w++;
    end
    req_valid = 1'b1;
    req_we    = we;
    req_addr  = a;
    req_wdata = d;
    tick;
    req_valid = 1'b0;
    req_we    = 1'b0;
    lat       = 1;
    while (!resp_valid && lat < 200) begin
      tick;
      lat++;
    end
    rd = resp_rdata;
    if (!resp_valid) lat = 999;
    tick;
  endtask

  task automatic test_reset;
    reset     = 1'b1;
    req_valid = 1'b0;
    req_we    = 1'b0;
    req_addr  = '0;
    req_wdata = '0;
    flush     = 1'b0;
    stall_cnt = 0;
    clear_log;
    tick;
    tick;
    checks++; if (req_ready !== 1'b0) begin fails++; $display("FAIL rst_req_ready: got %b want 0", req_ready); end
    checks++; if (resp_valid !== 1'b0) begin fails++; $display("FAIL rst_resp_valid: got %b want 0", resp_valid); end
    checks++; if (resp_rdata !== 32'h0) begin fails++; $display("FAIL rst_resp_rdata: got %h want 0", resp_rdata); end
    checks++; if ({mem_req_valid, mem_req_we} !== 2'b00) begin fails++; $display("FAIL rst_mem_ctl: got %b want 00", {mem_req_valid, mem_req_we}); end
    checks++; if ({mem_req_addr, mem_req_wdata} !== 48'h0) begin fails++; $display("FAIL rst_mem_bus: got %h want 0", {mem_req_addr, mem_req_wdata}); end
    checks++; if (flush_busy !== 1'b0) begin fails++; $display("FAIL rst_flush_busy: got %b want 0", flush_busy); end
    checks++; if ({stat_hits, stat_misses} !== 64'h0) begin fails++; $display("FAIL rst_stats: got %h want 0", {stat_hits, stat_misses}); end
    reset = 1'b0;
    #1;
    checks++; if (req_ready !== 1'b1) begin fails++; $display("FAIL rst_release_ready: got %b want 1", req_ready); end
    tick;
  endtask

  task automatic test_load_miss_hit;
    logic [31:0] rd;
    int lat;
    clear_log;
    do_req(1'b0, 16'h0123, 32'h0, rd, lat);
    checks++; if (rd !== 32'hA5A50123) begin fails++; $display("FAIL miss_data: got %h want a5a50123", rd); end
    checks++; if (lat !== 10) begin fails++; $display("FAIL miss_latency: got %0d want 10", lat); end
    checks++; if (n_rd !== 4) begin fails++; $display("FAIL miss_reads: got %0d want 4", n_rd); end
    for (int i = 0; i < 4; i++) begin
      checks++; if (rd_log[i] !== 16'h0120 + 16'(i)) begin fails++; $display("FAIL miss_beat_addr%0d: got %h want %h", i, rd_log[i], 16'h0120 + 16'(i)); end
    end
    checks++; if (stat_misses !== 32'd1 || stat_hits !== 32'd0) begin fails++; $display("FAIL miss_stats: got h=%0d m=%0d want h=0 m=1", stat_hits, stat_misses); end
    clear_log;
    do_req(1'b0, 16'h0123, 32'h0, rd, lat);
    checks++; if (rd !== 32'hA5A50123) begin fails++; $display("FAIL hit_data: got %h want a5a50123", rd); end
    checks++; if (lat !== 2) begin fails++; $display("FAIL hit_latency: got %0d want 2", lat); end
    checks++; if (n_rd + n_wr !== 0) begin fails++; $display("FAIL hit_traffic: got %0d want 0", n_rd + n_wr); end
    checks++; if (stat_hits !== 32'd1) begin fails++; $display("FAIL hit_stats: got %0d want 1", stat_hits); end
  endtask

  task automatic test_back_to_back;
    int acc   = 0;
    int nresp = 0;
    logic [8:0] acc_mask = '0;
    req_valid = 1'b1;
    req_we    = 1'b0;
    req_addr  = 16'h0122;
    for (int i = 0; i < 9; i++) begin
      if (req_ready) begin
        acc++;
        acc_mask[i] = 1'b1;
      end
      if (resp_valid) begin
        nresp++;
        checks++; if (resp_rdata !== 32'hA5A50122) begin fails++; $display("FAIL b2b_data: got %h want a5a50122", resp_rdata); end
      end
      tick;
    end
    req_valid = 1'b0;
    checks++; if (acc_mask !== 9'b001001001) begin fails++; $display("FAIL b2b_accept_pattern: got %b want 001001001", acc_mask); end
    checks++; if (nresp !== 3) begin fails++; $display("FAIL b2b_responses: got %0d want 3", nresp); end
    checks++; if (stat_hits !== 32'd4) begin fails++; $display("FAIL b2b_hits: got %0d want 4", stat_hits); end
    tick;
  endtask

  task automatic test_store_hit;
    logic [31:0] rd;
    int lat;
    clear_log;
    do_req(1'b1, 16'h0121, 32'hDEADBEEF, rd, lat);
    checks++; if (lat !== 3) begin fails++; $display("FAIL st_hit_latency: got %0d want 3", lat); end
    checks++; if (rd !== 32'h0) begin fails++; $display("FAIL st_hit_rdata: got %h want 0", rd); end
    checks++; if (n_wr !== 1 || n_rd !== 0) begin fails++; $display("FAIL st_hit_traffic: got wr=%0d rd=%0d want wr=1 rd=0", n_wr, n_rd); end
    checks++; if ({last_wr_addr, last_wr_data} !== {16'h0121, 32'hDEADBEEF}) begin fails++; $display("FAIL st_hit_write: got %h/%h want 0121/deadbeef", last_wr_addr, last_wr_data); end
    clear_log;
    do_req(1'b0, 16'h0121, 32'h0, rd, lat);
    checks++; if (rd !== 32'hDEADBEEF) begin fails++; $display("FAIL st_hit_reload: got %h want deadbeef", rd); end
    checks++; if (lat !== 2 || n_rd !== 0) begin fails++; $display("FAIL st_hit_reload_hit: got lat=%0d rd=%0d want lat=2 rd=0", lat, n_rd); end
    checks++; if (stat_hits !== 32'd6) begin fails++; $display("FAIL st_hit_stats: got %0d want 6", stat_hits); end
  endtask

  task automatic test_store_miss;
    logic [31:0] rd;
    int lat;
    clear_log;
    do_req(1'b1, 16'h4400, 32'h12345678, rd, lat);
    checks++; if (n_wr !== 1 || n_rd !== 0) begin fails++; $display("FAIL st_miss_traffic: got wr=%0d rd=%0d want wr=1 rd=0", n_wr, n_rd); end
    checks++; if (last_wr_addr !== 16'h4400) begin fails++; $display("FAIL st_miss_addr: got %h want 4400", last_wr_addr); end
    checks++; if (stat_misses !== 32'd2) begin fails++; $display("FAIL st_miss_stats: got %0d want 2", stat_misses); end
    clear_log;
    do_req(1'b0, 16'h4400, 32'h0, rd, lat);
    checks++; if (lat !== 10 || n_rd !== 4) begin fails++; $display("FAIL st_miss_reload: got lat=%0d rd=%0d want lat=10 rd=4", lat, n_rd); end
    checks++; if (rd !== 32'h12345678) begin fails++; $display("FAIL st_miss_reload_data: got %h want 12345678", rd); end
    checks++; if (stat_misses !== 32'd3) begin fails++; $display("FAIL st_miss_stats2: got %0d want 3", stat_misses); end
  endtask

  task automatic test_conflict;
    logic [31:0] rd;
    int lat;
    logic [15:0] addrs [3];
    addrs[0] = 16'h0004;
    addrs[1] = 16'h0404;
    addrs[2] = 16'h0004;
    for (int i = 0; i < 3; i++) begin
      clear_log;
      do_req(1'b0, addrs[i], 32'h0, rd, lat);
      checks++; if (lat !== 10 || n_rd !== 4) begin fails++; $display("FAIL conflict_miss%0d: got lat=%0d rd=%0d want lat=10 rd=4", i, lat, n_rd); end
      checks++; if (rd !== (32'(addrs[i]) ^ 32'hA5A5_0000)) begin fails++; $display("FAIL conflict_data%0d: got %h want %h", i, rd, 32'(addrs[i]) ^ 32'hA5A5_0000); end
    end
    checks++; if (stat_misses !== 32'd6) begin fails++; $display("FAIL conflict_stats: got %0d want 6", stat_misses); end
  endtask

  task automatic test_stall;
    logic [31:0] rd;
    int lat;
    clear_log;
    stall_cnt = 5;
    do_req(1'b0, 16'h0208, 32'h0, rd, lat);
    checks++; if (n_stall !== 5) begin fails++; $display("FAIL stall_cycles: got %0d want 5", n_stall); end
    checks++; if (n_unstable !== 0) begin fails++; $display("FAIL stall_stable: got %0d changes want 0", n_unstable); end
    checks++; if (stall_addr !== 16'h0208) begin fails++; $display("FAIL stall_addr: got %h want 0208", stall_addr); end
    checks++; if (lat !== 15) begin fails++; $display("FAIL stall_latency: got %0d want 15", lat); end
    checks++; if (rd !== 32'hA5A50208) begin fails++; $display("FAIL stall_data: got %h want a5a50208", rd); end
  endtask

  task automatic test_reset_mid_refill;
    logic [31:0] rd;
    int lat;
    req_valid = 1'b1;
    req_we    = 1'b0;
    req_addr  = 16'h0300;
    tick;
    req_valid = 1'b0;
    for (int i = 0; i < 4; i++) tick;
    reset = 1'b1;
    #1;
    checks++; if ({mem_req_valid, mem_req_we, mem_req_addr} !== 18'h0) begin fails++; $display("FAIL midrst_mem: got %h want 0", {mem_req_valid, mem_req_we, mem_req_addr}); end
    checks++; if ({req_ready, resp_valid, flush_busy} !== 3'b000) begin fails++; $display("FAIL midrst_ctl: got %b want 000", {req_ready, resp_valid, flush_busy}); end
    checks++; if ({stat_hits, stat_misses} !== 64'h0) begin fails++; $display("FAIL midrst_stats: got %h want 0", {stat_hits, stat_misses}); end
    tick;
    reset = 1'b0;
    tick;
    clear_log;
    do_req(1'b0, 16'h0300, 32'h0, rd, lat);
    checks++; if (lat !== 10 || rd !== 32'hA5A50300) begin fails++; $display("FAIL midrst_reload: got lat=%0d data=%h want 10/a5a50300", lat, rd); end
    clear_log;
    do_req(1'b0, 16'h0123, 32'h0, rd, lat);
    checks++; if (lat !== 10 || n_rd !== 4) begin fails++; $display("FAIL midrst_line_invalid: got lat=%0d rd=%0d want 10/4", lat, n_rd); end
    checks++; if (stat_misses !== 32'd2) begin fails++; $display("FAIL midrst_misses: got %0d want 2", stat_misses); end
  endtask

  task automatic test_flush;
    logic [31:0] rd;
    int lat;
    int busy      = 0;
    int bad_ready = 0;
    logic [15:0] addrs [3];
    addrs[0] = 16'h0010;
    addrs[1] = 16'h0020;
    addrs[2] = 16'h0030;
    for (int i = 0; i < 3; i++) do_req(1'b0, addrs[i], 32'h0, rd, lat);
    do_req(1'b0, 16'h0010, 32'h0, rd, lat);
    checks++; if (lat !== 2) begin fails++; $display("FAIL flush_prefill_hit: got %0d want 2", lat); end
    flush = 1'b1;
    tick;
    flush     = 1'b0;
    req_valid = 1'b1;
    req_addr  = 16'h0020;
    for (int c = 0; c < 400; c++) begin
      if (!flush_busy) break;
      busy++;
      if (req_ready) bad_ready++;
      flush = (busy == 10);
      tick;
    end
    req_valid = 1'b0;
    flush     = 1'b0;
    checks++; if (busy !== 257) begin fails++; $display("FAIL flush_busy_cycles: got %0d want 257", busy); end
    checks++; if (bad_ready !== 0) begin fails++; $display("FAIL flush_ready_low: got %0d ready cycles want 0", bad_ready); end
    checks++; if (stat_hits !== 32'd1 || stat_misses !== 32'd5) begin fails++; $display("FAIL flush_stats: got h=%0d m=%0d want h=1 m=5", stat_hits, stat_misses); end
    for (int i = 0; i < 3; i++) begin
      clear_log;
      do_req(1'b0, addrs[i], 32'h0, rd, lat);
      checks++; if (lat !== 10 || n_rd !== 4) begin fails++; $display("FAIL flush_reload%0d: got lat=%0d rd=%0d want 10/4", i, lat, n_rd); end
    end
    checks++; if (stat_misses !== 32'd8) begin fails++; $display("FAIL flush_misses: got %0d want 8", stat_misses); end
  endtask

  initial begin
    test_reset;
    test_load_miss_hit;
    test_back_to_back;
    test_store_hit;
    test_store_miss;
    test_conflict;
    test_stall;
    test_reset_mid_refill;
    test_flush;
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
